// File: rtl/fifo_writer_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module      : fifo_writer_pkg
// Description : Shared constants for the FIFO write-side adapter: default
//               widths and the skid-buffer occupancy state encoding.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
package fifo_writer_pkg;

  localparam int DEF_DWIDTH = 32;
  localparam int DEF_CWIDTH = 16;

  // Occupancy of the 2-entry skid buffer
  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_TWO   = 2'd2;

endpackage
`default_nettype wire

// File: rtl/fifo_writer_skid.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module      : hs_skid_buf
// Description : 2-entry skid buffer. Input ready is decoded purely from the
//               occupancy register so it carries no combinational path from
//               the output side. Head entry is always the oldest word.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
module hs_skid_buf
  import fifo_writer_pkg::*;
#(
  parameter int DWIDTH = DEF_DWIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [DWIDTH-1:0] i_in_data,
  output logic              o_out_valid,
  input  logic              i_out_take,
  output logic [DWIDTH-1:0] o_out_data,
  output logic              o_empty
);

  logic [1:0]        r_state;
  logic [DWIDTH-1:0] r_head;
  logic [DWIDTH-1:0] r_entry1;
  logic              w_in_xfer;
  logic              w_out_xfer;

  assign o_in_ready  = (r_state != OCC_TWO);
  assign o_out_valid = (r_state != OCC_EMPTY);
  assign o_empty     = (r_state == OCC_EMPTY);
  assign o_out_data  = r_head;

  assign w_in_xfer   = i_in_valid & o_in_ready;
  // A take while empty cannot happen from the top, but is masked anyway
  assign w_out_xfer  = i_out_take & o_out_valid;

  // Occupancy FSM and entry registers; entry1 only ever shifts into head
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= OCC_EMPTY;
      r_head   <= '0;
      r_entry1 <= '0;
    end else begin
      case (r_state)
        OCC_EMPTY: begin
          if (w_in_xfer) begin
            r_head  <= i_in_data;
            r_state <= OCC_ONE;
          end
        end
        OCC_ONE: begin
          if (w_in_xfer && w_out_xfer) begin
            // Head leaves this edge, incoming word takes its place
            r_head <= i_in_data;
          end else if (w_in_xfer) begin
            r_entry1 <= i_in_data;
            r_state  <= OCC_TWO;
          end else if (w_out_xfer) begin
            r_state <= OCC_EMPTY;
          end
        end
        OCC_TWO: begin
          if (w_out_xfer) begin
            r_head  <= r_entry1;
            r_state <= OCC_ONE;
          end
        end
        default: begin
          r_state <= OCC_EMPTY;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/fifo_writer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module      : fifo_writer
// Description : Producer-side adapter: accepts words over req/ack and writes
//               them to the shared FIFO through a 2-entry skid buffer, gating
//               the write request with fifo_full and counting written words.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
module fifo_writer
  import fifo_writer_pkg::*;
#(
  parameter int DWIDTH = DEF_DWIDTH,
  parameter int CWIDTH = DEF_CWIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req_in,
  output logic              o_ack_in,
  input  logic [DWIDTH-1:0] i_data_in,
  input  logic              i_fifo_full,
  output logic              o_req_out,
  input  logic              i_ack_out,
  output logic [DWIDTH-1:0] o_data_out,
  output logic              o_idle,
  output logic [CWIDTH-1:0] o_wr_count
);

  logic              w_buf_valid;
  logic              w_out_xfer;
  logic [CWIDTH-1:0] r_wr_count;

  // fifo_full is the only input allowed to move req_out mid-cycle
  assign o_req_out  = w_buf_valid & ~i_fifo_full;
  // ack_out without a pending request is ignored
  assign w_out_xfer = o_req_out & i_ack_out;
  assign o_wr_count = r_wr_count;

  hs_skid_buf #(
    .DWIDTH (DWIDTH)
  ) u_skid (
    .clk         (clk),
    .rst         (rst),
    .i_in_valid  (i_req_in),
    .o_in_ready  (o_ack_in),
    .i_in_data   (i_data_in),
    .o_out_valid (w_buf_valid),
    .i_out_take  (w_out_xfer),
    .o_out_data  (o_data_out),
    .o_empty     (o_idle)
  );

  // Written-word counter, wraps naturally at 2^CWIDTH
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_count <= '0;
    end else if (w_out_xfer) begin
      r_wr_count <= r_wr_count + CWIDTH'(1);
    end
  end

endmodule
`default_nettype wire
